// File: rtl/mux_scan.sv
// N-channel registered multiplexer with manual select and dwell-timed round-robin scan.
// y/ch/y_valid all update on the same edge; y_valid flags each new sample period.
module mux_scan #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 8,
  parameter  int DWELL    = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      y_valid
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NSLOT = 1 << SELW;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [SELW:0] CH_COUNT = (SELW + 1)'(CHANNELS);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [DW-1:0]    r_dwell;
  logic [DW-1:0]    w_dwell_n;
  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_ch;
  logic [SELW-1:0]  w_ch_n;
  logic [SELW-1:0]  w_next_en;
  logic [SELW-1:0]  w_sel_ch;
  logic             w_sel_ok;
  logic [SELW:0]    w_sum;
  logic [SELW:0]    w_idx;
  logic             r_valid;
  logic             w_valid_n;
  logic [WIDTH-1:0] w_chan [NSLOT];

  // Unused slots of a non-power-of-two channel count read as zero and are never selected.
  for (genvar g = 0; g < NSLOT; g++) begin : g_chan
    if (g < CHANNELS) begin : g_used
      assign w_chan[g] = din[g*WIDTH +: WIDTH];
    end else begin : g_unused
      assign w_chan[g] = '0;
    end
  end

  assign w_sel_ok = ({1'b0, sel} < CH_COUNT);
  assign w_sel_ch = w_sel_ok ? sel : r_ch;

  // Search upward from ch+1 with wrap; the nearest enabled channel wins, else ch holds.
  always_comb begin
    w_next_en = r_ch;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      w_sum     = {1'b0, r_ch} + (SELW + 1)'(i);
      w_idx     = (w_sum >= CH_COUNT) ? (w_sum - CH_COUNT) : w_sum;
      w_next_en = en_mask[w_idx[SELW-1:0]] ? w_idx[SELW-1:0] : w_next_en;
    end
  end

  // Next state, next channel, dwell counter and strobe decision.
  always_comb begin
    w_state_n = r_state;
    w_dwell_n = '0;
    w_ch_n    = r_ch;
    w_valid_n = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        if (mode) begin
          w_state_n = ST_SCAN;
        end else begin
          w_ch_n    = w_sel_ch;
          w_valid_n = (w_sel_ch != r_ch);
        end
      end
      ST_SCAN: begin
        if (!mode) begin
          w_state_n = ST_MANUAL;
          w_ch_n    = w_sel_ch;
          w_valid_n = 1'b1;
        end else begin
          w_dwell_n = (r_dwell == DWELL_LAST) ? '0 : (r_dwell + 1'b1);
          if ((r_dwell == DWELL_LAST) && (|en_mask)) begin
            w_ch_n    = w_next_en;
            w_valid_n = 1'b1;
          end else begin
            w_ch_n    = r_ch;
          end
        end
      end
      default: begin
        w_state_n = ST_MANUAL;
      end
    endcase
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MANUAL;
      r_dwell <= '0;
      r_ch    <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_dwell <= w_dwell_n;
      r_ch    <= w_ch_n;
      r_y     <= w_chan[w_ch_n];
      r_valid <= w_valid_n;
    end
  end

  assign y       = r_y;
  assign ch      = r_ch;
  assign y_valid = r_valid;

endmodule
